// File: rtl/tdc_interval_builder.sv
// rtl/tdc_interval_builder.sv - TDC start/stop interval builder (optional offset correction: TDC_OFFSET_CORR_EN)
module tdc_interval_builder #(
    parameter int BITS_DECO   = 8,
    parameter int COARSE_BITS = 16,
    parameter int CLK_BINS    = 240,
    parameter int OUT_BITS    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_hit,
    input  logic [BITS_DECO-1:0]  start_bin,
    input  logic                  stop_hit,
    input  logic [BITS_DECO-1:0]  stop_bin,
`ifdef TDC_OFFSET_CORR_EN
    input  logic [BITS_DECO+3:0]  offset_corr,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BITS-1:0]   out_interval,
    output logic                  out_ovf,
    output logic                  out_err,
    output logic                  busy,
    output logic                  drop
);

    localparam int CALC_W = OUT_BITS + 1;
    localparam logic [COARSE_BITS-1:0] COARSE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [COARSE_BITS-1:0] coarse;
    logic [BITS_DECO-1:0]   start_q;
    logic [BITS_DECO-1:0]   stop_q;
    logic                   ovf_q;
    logic [CALC_W-1:0]      fine_sum;
    logic [CALC_W-1:0]      corr_sum;
    logic [OUT_BITS-1:0]    res_interval;
    logic                   res_err;
    logic                   hit_ignored;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_hit) state_nxt = stop_hit ? CALC : RUN;
            RUN:  if (stop_hit || coarse == COARSE_MAX) state_nxt = CALC;
            CALC: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Two's-complement in CALC_W bits; the top bit is the sign of the combined interval.
    always_comb begin
        fine_sum = CALC_W'(coarse) * CALC_W'(CLK_BINS) + CALC_W'(start_q) - CALC_W'(stop_q);
`ifdef TDC_OFFSET_CORR_EN
        corr_sum = fine_sum - CALC_W'(offset_corr);
`else
        corr_sum = fine_sum;
`endif
        res_interval = corr_sum[OUT_BITS-1:0];
        res_err      = 1'b0;
        if (ovf_q) begin
            res_interval = '1;
        end else if (corr_sum[CALC_W-1]) begin
            res_interval = '0;
            res_err      = 1'b1;
        end
    end

    assign hit_ignored = ((state == RUN) && start_hit) ||
                         (((state == CALC) || (state == DONE)) && (start_hit || stop_hit));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse       <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            ovf_q        <= 1'b0;
            out_valid    <= 1'b0;
            out_interval <= '0;
            out_ovf      <= 1'b0;
            out_err      <= 1'b0;
            drop         <= 1'b0;
        end else begin
            if (hit_ignored) drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_hit) begin
                        start_q <= start_bin;
                        coarse  <= '0;
                        ovf_q   <= 1'b0;
                        if (stop_hit) stop_q <= stop_bin;
                    end
                end
                RUN: begin
                    // Counter saturates: a stop landing on the timeout cycle keeps the max count.
                    if (stop_hit) begin
                        stop_q <= stop_bin;
                        if (coarse != COARSE_MAX) coarse <= coarse + 1'b1;
                    end else if (coarse == COARSE_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        coarse <= coarse + 1'b1;
                    end
                end
                CALC: begin
                    out_valid    <= 1'b1;
                    out_interval <= res_interval;
                    out_ovf      <= ovf_q;
                    out_err      <= res_err;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_interval_builder.sv
// tb/tb_tdc_interval_builder.sv - randomized self-checking bench for tdc_interval_builder
module tb_tdc_interval_builder;

    localparam int BITS_DECO   = 8;
    localparam int COARSE_BITS = 4;
    localparam int CLK_BINS    = 240;
    localparam int OUT_BITS    = 24;
    localparam int CMAX        = (1 << COARSE_BITS) - 1;
    localparam int OVF_D       = 1000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_hit = 1'b0;
    logic                 stop_hit = 1'b0;
    logic [BITS_DECO-1:0] start_bin = '0;
    logic [BITS_DECO-1:0] stop_bin = '0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [OUT_BITS-1:0]  out_interval;
    logic                 out_ovf;
    logic                 out_err;
    logic                 busy;
    logic                 drop;
    int                   cur_off = 0;
    int                   n_cmp = 0;
    int                   n_bad = 0;
`ifdef TDC_OFFSET_CORR_EN
    logic [BITS_DECO+3:0] offset_corr = '0;
    always_comb offset_corr = cur_off[BITS_DECO+3:0];
`endif

    tdc_interval_builder #(
        .BITS_DECO(BITS_DECO), .COARSE_BITS(COARSE_BITS),
        .CLK_BINS(CLK_BINS), .OUT_BITS(OUT_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_hit(start_hit), .start_bin(start_bin),
        .stop_hit(stop_hit), .stop_bin(stop_bin),
`ifdef TDC_OFFSET_CORR_EN
        .offset_corr(offset_corr),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_interval(out_interval), .out_ovf(out_ovf), .out_err(out_err),
        .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // d = number of clock edges from start sample to stop sample; d > CMAX+1 means no stop is sent.
    function automatic void model(input int sb, input int pb, input int d, input int off,
                                  output logic [OUT_BITS-1:0] iv, output logic ovf, output logic err);
        longint v;
        int c;
        ovf = 1'b0;
        err = 1'b0;
        if (d > CMAX + 1) begin
            iv  = '1;
            ovf = 1'b1;
            return;
        end
        c = (d > CMAX) ? CMAX : d;
        v = longint'(c) * CLK_BINS + sb - pb;
`ifdef TDC_OFFSET_CORR_EN
        v = v - off;
`else
        if (off != 0) v = v;
`endif
        if (v < 0) begin
            iv  = '0;
            err = 1'b1;
        end else begin
            iv = v[OUT_BITS-1:0];
        end
    endfunction

    task automatic measure(input string name, input int sb, input int pb, input int d, input int rdy_wait);
        logic [OUT_BITS-1:0] eiv;
        logic eovf, eerr;
        int lat, exp_lat;
        model(sb, pb, d, cur_off, eiv, eovf, eerr);
        exp_lat = (d > CMAX + 1) ? CMAX + 2 : 1;
        start_bin = sb[BITS_DECO-1:0];
        stop_bin  = pb[BITS_DECO-1:0];
        start_hit = 1'b1;
        stop_hit  = (d == 0);
        tick;
        start_hit = 1'b0;
        stop_hit  = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        if (d > 0 && d <= CMAX + 1) begin
            repeat (d - 1) tick;
            stop_hit = 1'b1;
            tick;
            stop_hit = 1'b0;
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        for (int k = 0; k <= rdy_wait; k++) begin
            if (k > 0) tick;
            n_cmp++;
            if (out_valid !== 1'b1 || out_interval !== eiv || out_ovf !== eovf || out_err !== eerr) begin
                n_bad++;
                $display("FAIL %s result[%0d]: got v=%b iv=%0d ovf=%b err=%b want v=1 iv=%0d ovf=%b err=%b",
                         name, k, out_valid, out_interval, out_ovf, out_err, eiv, eovf, eerr);
            end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release: got v=%b busy=%b want v=0 busy=0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        n_cmp++;
        if ({out_valid, out_interval, out_ovf, out_err, busy, drop} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b iv=%0d ovf=%b err=%b busy=%b drop=%b want all 0",
                     out_valid, out_interval, out_ovf, out_err, busy, drop);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        measure("basic", 100, 40, 5, 0);
        measure("basic_hold", 7, 200, 1, 2);
    endtask

    task automatic test_simultaneous;
        measure("simul_neg", 30, 50, 0, 0);
        measure("simul_pos", 50, 30, 0, 1);
    endtask

    task automatic test_idle_stop;
        stop_hit = 1'b1;
        stop_bin = 8'd77;
        tick;
        stop_hit = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if (busy !== 1'b0 || drop !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_stop: got busy=%b drop=%b v=%b want 0 0 0", busy, drop, out_valid);
        end
    endtask

    task automatic test_timeout;
        measure("timeout_ovf", 12, 3, OVF_D, 1);
        measure("stop_at_max", 200, 10, CMAX, 0);
        measure("stop_on_timeout", 5, 9, CMAX + 1, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            int d;
            d = $urandom_range(0, CMAX + 3);
            if (d > CMAX + 1) d = OVF_D;
`ifdef TDC_OFFSET_CORR_EN
            cur_off = $urandom_range(0, 700);
`endif
            measure("random", $urandom_range(0, 255), $urandom_range(0, 255), d, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick;
        end
        cur_off = 0;
        n_cmp++;
        if (drop !== 1'b0) begin
            n_bad++;
            $display("FAIL random_no_drop: got %b want 0", drop);
        end
    endtask

`ifdef TDC_OFFSET_CORR_EN
    task automatic test_offset;
        cur_off = 60;
        measure("offset_60", 10, 20, 2, 0);
        cur_off = 600;
        measure("offset_600", 10, 20, 2, 0);
        cur_off = 60;
        measure("offset_ovf", 10, 20, OVF_D, 0);
        cur_off = 0;
    endtask
`endif

    task automatic test_drop;
        logic [OUT_BITS-1:0] held;
        start_bin = 8'd9;
        start_hit = 1'b1;
        tick;
        start_hit = 1'b0;
        start_hit = 1'b1;
        tick;
        start_hit = 1'b0;
        n_cmp++;
        if (drop !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_in_run: got %b want 1", drop);
        end
        stop_bin = 8'd4;
        stop_hit = 1'b1;
        tick;
        stop_hit = 1'b0;
        tick;
        held = out_interval;
        n_cmp++;
        if (out_valid !== 1'b1 || held !== OUT_BITS'(2 * CLK_BINS + 9 - 4)) begin
            n_bad++;
            $display("FAIL drop_result: got v=%b iv=%0d want v=1 iv=%0d", out_valid, held, 2 * CLK_BINS + 5);
        end
        for (int k = 0; k < 10; k++) begin
            start_hit = k[0];
            stop_hit  = ~k[0];
            tick;
        end
        start_hit = 1'b0;
        stop_hit  = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_interval !== held || drop !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_hold: got v=%b iv=%0d drop=%b want v=1 iv=%0d drop=1",
                     out_valid, out_interval, drop, held);
        end
        out_ready = 1'b1;
        start_hit = 1'b1;
        tick;
        out_ready = 1'b0;
        start_hit = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_handshake_start: got v=%b busy=%b want 0 0", out_valid, busy);
        end
        measure("after_drop", 150, 60, 3, 0);
    endtask

    task automatic test_async_reset;
        int seen;
        start_bin = 8'd1;
        start_hit = 1'b1;
        tick;
        start_hit = 1'b0;
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || drop !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_run: got busy=%b v=%b drop=%b want 0 0 0", busy, out_valid, drop);
        end
        tick;
        rst_n = 1'b1;
        start_hit = 1'b1;
        stop_hit  = 1'b1;
        start_bin = 8'd90;
        stop_bin  = 8'd10;
        tick;
        start_hit = 1'b1;
        stop_hit  = 1'b0;
        tick;
        start_hit = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_interval, out_ovf, out_err, busy, drop} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_done: got v=%b iv=%0d ovf=%b err=%b busy=%b drop=%b want all 0",
                     out_valid, out_interval, out_ovf, out_err, busy, drop);
        end
        tick;
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            tick;
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL no_output_after_reset: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_simultaneous;
        test_idle_stop;
        test_timeout;
        test_random;
`ifdef TDC_OFFSET_CORR_EN
        test_offset;
`endif
        test_drop;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
